mac_share_arbiter: RTL

Round-robin scheduler that shares a single MAC16_wrapper DSP slice between NUM_REQ datapath requesters, for example per-channel or per-stage biquad engines. A granted requester streams operand pairs in a burst. The arbiter owns the 48-bit accumulator, drives the MAC a_in/b_in/c_in, and returns both the raw accumulation and a rounded, saturated Q2.14 result tagged with the requester ID. It sits between the filter sequencers and the one physical DSP slice.

---
 rtl/mac_share_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one MAC slice between NUM_REQ burst requesters
module mac_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [16*NUM_REQ-1:0]      op_a_flat,
  input  logic [16*NUM_REQ-1:0]      op_b_flat,
  input  logic [NUM_REQ-1:0]         op_valid,
  input  logic [NUM_REQ-1:0]         op_last,
  output logic [NUM_REQ-1:0]         grant,
  output logic [15:0]                mac_a,
  output logic [15:0]                mac_b,
  output logic [47:0]                mac_c,
  input  logic [47:0]                mac_result,
  output logic                       result_valid,
  output logic [$clog2(NUM_REQ)-1:0] result_id,
  output logic [47:0]                result_acc,
  output logic [15:0]                result_q,
  output logic                       timeout_err,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_last, w_sel, w_j;
  logic [47:0]     r_acc;
  logic [CW-1:0]   r_idle;
  logic            w_found, w_gv, w_gl, w_tmo;
  logic [15:0]     w_a, w_b, w_q;
  logic signed [34:0] w_t;
  // r_last doubles as the granted index while in BURST
  always_comb begin
    w_found = 1'b0;
    w_sel = '0;
    w_j = '0;
    w_a = '0;
    w_b = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = IW'((int'(r_last) + k) % NUM_REQ);
      if (req[w_j]) begin
        w_found = 1'b1;
        w_sel = w_j;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (r_last == IW'(i)) begin
        w_a = op_a_flat[16*i +: 16];
        w_b = op_b_flat[16*i +: 16];
      end
    w_gv = (r_state == BURST) && op_valid[r_last];
    w_gl = op_last[r_last];
    w_tmo = (r_state == BURST) && !w_gv && (r_idle == CW'(TIMEOUT - 1));
    w_next = (r_state == IDLE) ? (w_found ? BURST : IDLE)
                               : (((w_gv && w_gl) || w_tmo) ? IDLE : BURST);
  end
  assign mac_a = w_gv ? w_a : '0;
  assign mac_b = w_gv ? w_b : '0;
  assign mac_c = r_acc;
  assign busy  = (r_state == BURST);
  // round half up: floor(x / 2^14) plus the bit just below the cut
  assign w_t = 35'($signed(mac_result[47:14])) + 35'(mac_result[13]);
  assign w_q = (w_t > 35'sd32767) ? 16'h7fff : (w_t < -35'sd32768) ? 16'h8000 : w_t[15:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last       <= IW'(NUM_REQ - 1);
      r_acc        <= '0;
      r_idle       <= '0;
      grant        <= '0;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_acc   <= '0;
      result_q     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (w_found) begin
          grant  <= NUM_REQ'(1) << w_sel;
          r_last <= w_sel;
          r_acc  <= '0;
          r_idle <= '0;
        end
      end else if (w_gv) begin
        r_idle <= '0;
        if (w_gl) begin
          result_acc   <= mac_result;
          result_q     <= w_q;
          result_id    <= r_last;
          result_valid <= 1'b1;
          grant        <= '0;
        end else
          r_acc <= mac_result;
      end else begin
        r_idle <= r_idle + CW'(1);
        if (w_tmo) begin
          timeout_err <= 1'b1;
          grant       <= '0;
        end
      end
    end
  end
endmodule
